// File: rtl/culsans_pkg.sv
// culsans_pkg
// Shared definitions for the culsans SRAM arbiter slice.
//   DRAMBase        : byte address that maps onto SRAM word 0 by default
//   MaxPortIdxWidth : width of the port-index field in the response record
//   resp_t          : one-stage response record (port index, read flag, error, valid)
package culsans_pkg;

   localparam logic [63:0] DRAMBase = 64'h0000_0000_8000_0000;

   // Fixed-width index field so the record can live in the package while the
   // arbiter stays parameterised on the number of ports.
   localparam int unsigned MaxPortIdxWidth = 8;

   // 'rd' separates read responses, which forward SRAM data, from write
   // responses, which return zero data.
   typedef struct packed {
      logic [MaxPortIdxWidth-1:0] port;
      logic                       rd;
      logic                       err;
      logic                       valid;
   } resp_t;

endpackage

// File: rtl/culsans_rr_arbiter.sv
// culsans_rr_arbiter
// Combinational round-robin selector.
//   req_i   : request vector, one bit per port
//   ptr_i   : port index the search starts from
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted port
//   valid_o : high when some port is granted
module culsans_rr_arbiter #(
   parameter  int unsigned NumPorts = 2,
   localparam int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic [NumPorts-1:0] req_i,
   input  logic [IdxWidth-1:0] ptr_i,
   output logic [NumPorts-1:0] gnt_o,
   output logic [IdxWidth-1:0] idx_o,
   output logic                valid_o
);

   // Walk the ports starting at ptr_i and wrapping around; the first
   // requester seen wins. Wrap is done by subtraction so that port counts
   // that are not a power of two also work.
   always_comb begin
      int unsigned         cand;
      logic [IdxWidth-1:0] candIdx;
      cand    = 0;
      candIdx = '0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         cand = 32'(ptr_i) + i;
         if (cand >= NumPorts) begin
            cand = cand - NumPorts;
         end
         candIdx = IdxWidth'(cand);
         if (!valid_o && req_i[candIdx]) begin
            valid_o        = 1'b1;
            gnt_o[candIdx] = 1'b1;
            idx_o          = candIdx;
         end
      end
   end

endmodule

// File: rtl/culsans_sram_arbiter.sv
// culsans_sram_arbiter
// Shares one single-port SRAM between NumPorts requesters with round-robin
// arbitration. Grants are combinational; every grant yields one response
// pulse on the granted port one cycle later.
//   clk_i, rst_ni                     : clock, async active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i    : per-port request channel (byte address)
//   gnt_o                             : per-port grant, same cycle as request
//   rvalid_o/rdata_o/err_o            : per-port response, one cycle after grant
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_be_o              : SRAM command (word index)
//   mem_rdata_i                       : SRAM read data, one cycle after mem_req_o
module culsans_sram_arbiter
   import culsans_pkg::*;
#(
   parameter  int unsigned NumPorts     = 2,
   parameter  int unsigned NumWords     = 4096,
   parameter  int unsigned DataWidth    = 64,
   parameter  int unsigned AddrWidth    = 64,
   parameter  logic [63:0] BaseAddr     = DRAMBase,
   localparam int unsigned BeWidth      = DataWidth / 8,
   localparam int unsigned MemAddrWidth = $clog2(NumWords),
   localparam int unsigned IdxWidth     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumPorts-1:0]                 req_i,
   input  logic [NumPorts-1:0]                 we_i,
   input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
   input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
   output logic [NumPorts-1:0]                 gnt_o,
   output logic [NumPorts-1:0]                 rvalid_o,
   output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
   output logic [NumPorts-1:0]                 err_o,
   output logic                                mem_req_o,
   output logic                                mem_we_o,
   output logic [MemAddrWidth-1:0]             mem_addr_o,
   output logic [DataWidth-1:0]                mem_wdata_o,
   output logic [BeWidth-1:0]                  mem_be_o,
   input  logic [DataWidth-1:0]                mem_rdata_i
);

   localparam logic [AddrWidth-1:0] BaseA     = AddrWidth'(BaseAddr);
   localparam int unsigned          WordShift = $clog2(BeWidth);

   logic [NumPorts-1:0]  reqMasked;
   logic [IdxWidth-1:0]  rrPtr_q, rrPtr_d;
   logic [IdxWidth-1:0]  gntIdx;
   logic                 gntValid;
   logic [AddrWidth-1:0] selAddr, wordIdx;
   logic                 selWe, inRange, memHit;
   resp_t                resp_q, resp_d;

   // Grants are combinational, so requests are masked while reset is held to
   // keep gnt_o low during reset.
   assign reqMasked = req_i & {NumPorts{rst_ni}};

   culsans_rr_arbiter #(
      .NumPorts (NumPorts)
   ) i_rr_arbiter (
      .req_i   (reqMasked),
      .ptr_i   (rrPtr_q),
      .gnt_o   (gnt_o),
      .idx_o   (gntIdx),
      .valid_o (gntValid)
   );

   // Address decode for the granted port. The explicit lower-bound compare
   // catches addresses below BaseAddr whose wrapped offset could otherwise
   // land back inside the SRAM for narrow address widths.
   assign selAddr = addr_i[gntIdx];
   assign selWe   = we_i[gntIdx];
   assign wordIdx = (selAddr - BaseA) >> WordShift;
   assign inRange = (selAddr >= BaseA) && (wordIdx < AddrWidth'(NumWords));
   assign memHit  = gntValid && inRange;

   // The SRAM command is zeroed when idle or out of range, so an
   // out-of-range grant is consumed without touching the memory.
   assign mem_req_o   = memHit;
   assign mem_we_o    = memHit && selWe;
   assign mem_addr_o  = memHit ? wordIdx[MemAddrWidth-1:0] : '0;
   assign mem_wdata_o = memHit ? wdata_i[gntIdx] : '0;
   assign mem_be_o    = memHit ? be_i[gntIdx] : '0;

   // Next pointer sits one past the winner; it holds when nobody is granted.
   // The response record captures every grant, including errored ones.
   always_comb begin
      rrPtr_d = rrPtr_q;
      if (gntValid) begin
         rrPtr_d = (gntIdx == IdxWidth'(NumPorts - 1)) ? '0 : gntIdx + IdxWidth'(1);
      end
      resp_d.port  = MaxPortIdxWidth'(gntIdx);
      resp_d.rd    = !selWe;
      resp_d.err   = !inRange;
      resp_d.valid = gntValid;
   end

   // Single register stage for the round-robin pointer and the response.
   // Reset discards any in-flight response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rrPtr_q <= '0;
         resp_q  <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
         resp_q  <= resp_d;
      end
   end

   // Fan the response out to its port only. Read data is forwarded
   // straight from the SRAM, which presents it in this cycle.
   always_comb begin
      logic hit;
      hit      = 1'b0;
      rvalid_o = '0;
      err_o    = '0;
      rdata_o  = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         hit         = resp_q.valid && (resp_q.port == MaxPortIdxWidth'(p));
         rvalid_o[p] = hit;
         err_o[p]    = hit && resp_q.err;
         if (hit && resp_q.rd && !resp_q.err) begin
            rdata_o[p] = mem_rdata_i;
         end
      end
   end

endmodule

// File: doc/culsans_sram_arbiter.md
CULSANS_SRAM_ARBITER -- requirements
Module: culsans_sram_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of requesters.
REQ-002 SHALL have parameter NumWords, default 4096: SRAM depth in words.
REQ-003 SHALL have parameter DataWidth, default 64: word width in bits.
REQ-004 SHALL have parameter AddrWidth, default 64: requester byte-address width.
REQ-005 SHALL have parameter BaseAddr, default culsans_pkg::DRAMBase: byte address of word 0.
REQ-006 clk_i  input  1  clock; one clock only.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 req_i  input  NumPorts  per-port request.
REQ-009 we_i  input  NumPorts  per-port write enable.
REQ-010 addr_i  input  NumPorts x AddrWidth  per-port byte address.
REQ-011 wdata_i  input  NumPorts x DataWidth  per-port write data.
REQ-012 be_i  input  NumPorts x DataWidth/8  per-port byte enables.
REQ-013 gnt_o  output  NumPorts  per-port grant.
REQ-014 rvalid_o  output  NumPorts  per-port response valid.
REQ-015 rdata_o  output  NumPorts x DataWidth  per-port read data.
REQ-016 err_o  output  NumPorts  per-port out-of-range flag, qualified by rvalid_o.
REQ-017 mem_req_o  output  1  SRAM request.
REQ-018 mem_we_o  output  1  SRAM write enable.
REQ-019 mem_addr_o  output  clog2(NumWords)  SRAM word index.
REQ-020 mem_wdata_o / mem_be_o  output  DataWidth / DataWidth/8  SRAM write data / byte enables.
REQ-021 mem_rdata_i  input  DataWidth  SRAM read data, valid one cycle after mem_req_o.

Function
REQ-022 Arbiter SHALL assert at most one gnt_o bit per cycle, combinationally, in the same cycle as the granted req_i.
REQ-023 Arbitration SHALL be round-robin: search starts at rr_ptr; after a grant to port k, rr_ptr SHALL become (k+1) mod NumPorts at the next edge.
REQ-024 With no request, rr_ptr SHALL hold and gnt_o SHALL be 0.
REQ-025 Word index SHALL be (addr_i - BaseAddr) >> log2(DataWidth/8); in-range means 0 <= index < NumWords with unsigned compare; underflow below BaseAddr is out of range.
REQ-026 In-range grant: mem_req_o=1, with mem_we_o/addr/wdata/be driven from the granted port in the same cycle.
REQ-027 Out-of-range grant: mem_req_o=0; request still granted and consumed.
REQ-028 Every grant (read or write) SHALL produce exactly one rvalid_o pulse on the same port one cycle later; one response register stage holding port index, error and valid.
REQ-029 Read response: rdata_o = mem_rdata_i, err_o=0; write response: rdata_o = 0, err_o=0; out-of-range: rdata_o = 0, err_o=1.
REQ-030 rdata_o and err_o SHALL be 0 on all non-responding ports.
REQ-031 Back-to-back grants SHALL sustain one transaction per cycle; grant N+1 and response N coincide without loss.
REQ-032 A requester holding req_i without gnt_o SHALL keep the request pending; its grant SHALL arrive within NumPorts cycles under any competing load (starvation bound).

Reset
REQ-033 While rst_ni=0: rr_ptr=0, response valid=0, so gnt_o, rvalid_o, err_o, mem_req_o = 0 and rdata_o = 0.
REQ-034 Reset asserted mid-transaction SHALL drop the in-flight response; no rvalid_o after release for a pre-reset grant.
REQ-035 First cycle after release SHALL arbitrate from port 0.

Structure
REQ-036 DRAMBase and the response-record typedef (port index, err, valid) SHALL reside in culsans_pkg.
REQ-037 Round-robin selection SHALL be a sub-module culsans_rr_arbiter (req vector, ptr in, one-hot gnt out, index out).

Verification
REQ-038 Single read: port 0, addr BaseAddr+0x40, SRAM word 8 = 0xDEAD_BEEF -> gnt_o[0] same cycle, mem_addr_o=8, rvalid_o[0] and rdata_o=0xDEAD_BEEF next cycle.
REQ-039 Contention: both ports request continuously for 6 cycles from reset -> grants 0,1,0,1,0,1; each port gets 3 rvalid pulses.
REQ-040 Write then read: port 1 writes 0x1234 with be=0x03 to index 5 (prior 0xFFFF_FFFF_FFFF_FFFF) -> read returns 0xFFFF_FFFF_FFFF_1234.
REQ-041 Out-of-range: port 0 addr BaseAddr+NumWords*8 and BaseAddr-8 -> mem_req_o=0, rvalid_o[0]=1, err_o[0]=1, rdata_o=0.
REQ-042 Reset mid-op: grant read to port 1, drop rst_ni in the response cycle -> rvalid_o stays 0; after release, first grant goes to port 0 when both request.
REQ-043 Idle: no req for 10 cycles -> all outputs 0, rr_ptr unchanged.
